// File: rtl/gba_mem_bus.sv
// gba_mem_bus: GBA bus controller with region decode, wait states and byte-lane steering.
// Define GBA_MEMBUS_WAITSTATE_EN to enable per-region wait states (ROM_WAIT, EWRAM_WAIT).
module gba_mem_bus #(
    parameter int ROM_WAIT   = 4,
    parameter int EWRAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic [1:0]  mem_width,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_ok,
    output logic        ram_req,
    output logic        ram_we,
    output logic [3:0]  ram_region,
    output logic [23:0] ram_addr,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  width_q, off_q;
    logic [31:0] rdata_q, rdata_d, rot, rsel, wdata_d;
    logic [3:0]  region, be_d;
    logic        req, accept, mapped, rdonly, reject, unused_bits;

    assign req    = mem_read | mem_write;
    assign region = mem_addr[27:24];
    assign mapped = region == 4'h0 || (region >= 4'h2 && region <= 4'hE);
    assign rdonly = region == 4'h0 || (region >= 4'h8 && region <= 4'hD);
    assign reject = !mapped || (mem_write && rdonly);
    assign accept = state_q == IDLE && req;

    assign be_d    = mem_width[1] ? 4'hF : mem_width[0] ? (mem_addr[1] ? 4'hC : 4'h3) : 4'b0001 << mem_addr[1:0];
    assign wdata_d = mem_width[1] ? mem_wdata : mem_width[0] ? {2{mem_wdata[15:0]}} : {4{mem_wdata[7:0]}};

    // ARM misaligned word loads rotate; narrower loads pick a lane and zero-extend
    assign rot  = 32'({ram_rdata, ram_rdata} >> {off_q, 3'b000});
    assign rsel = width_q[1] ? rot :
                  width_q[0] ? {16'h0, off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0]} :
                  {24'h0, rot[7:0]};

    assign ram_req   = state_q == ACCESS;
    assign mem_ok    = state_q == DONE;
    assign mem_rdata = rdata_q;

`ifdef GBA_MEMBUS_WAITSTATE_EN
    localparam logic [2:0] ROM_W   = ROM_WAIT > 7 ? 3'd7 : 3'(ROM_WAIT);
    localparam logic [2:0] EWRAM_W = EWRAM_WAIT > 7 ? 3'd7 : 3'(EWRAM_WAIT);
    logic [2:0] cnt_q, cnt_d, wait_cnt;

    assign wait_cnt    = (region >= 4'h8 && region <= 4'hE) ? ROM_W : region == 4'h2 ? EWRAM_W : 3'd0;
    assign unused_bits = ^mem_addr[31:28];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign unused_bits = ^{mem_addr[31:28], ROM_WAIT, EWRAM_WAIT};
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef GBA_MEMBUS_WAITSTATE_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (req) begin
                if (reject) begin
                    state_d = DONE;
                    rdata_d = '0;
                end
`ifdef GBA_MEMBUS_WAITSTATE_EN
                else if (wait_cnt != 3'd0) begin
                    state_d = WAIT;
                    cnt_d   = wait_cnt;
                end
`endif
                else state_d = ACCESS;
            end
`ifdef GBA_MEMBUS_WAITSTATE_EN
            WAIT: begin
                cnt_d   = cnt_q - 3'd1;
                state_d = !req ? IDLE : cnt_q == 3'd1 ? ACCESS : WAIT;
            end
`else
            WAIT: state_d = IDLE;
`endif
            // a dropped request still finishes the handshake, but completes silently
            ACCESS: if (ram_ack) begin
                state_d = req ? DONE : IDLE;
                rdata_d = req ? rsel : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            width_q    <= '0;
            off_q      <= '0;
            ram_we     <= 1'b0;
            ram_region <= '0;
            ram_addr   <= '0;
            ram_be     <= '0;
            ram_wdata  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (accept) begin
                width_q    <= mem_width;
                off_q      <= mem_addr[1:0];
                ram_we     <= mem_write;
                ram_region <= region;
                ram_addr   <= {mem_addr[23:2], 2'b00};
                ram_be     <= be_d;
                ram_wdata  <= wdata_d;
            end
        end
    end
endmodule
